mmio_pwm_responder: RTL and testbench
=====================================

# mmio_pwm_responder

Memory-mapped I/O responder on the far side of the processor's data-memory port. It decodes IO loads and stores by address bits [13:12] and holds per-channel pulse-width registers. It drives glitch-free, frame-synchronised PWM waveforms on the JA header pins, and returns status and counter values to processor loads in the same cycle.

## Interface
- NUM_CH, 6, number of PWM channels / JA pins
- PERIOD, 1000000, frame length in clock cycles (20 ms at 50 MHz); must be ≥ 2
- CNT_W, 20, width of frame counter and width registers; must satisfy 2^CNT_W ≥ PERIOD
- clock  in  1  master clock, rising-edge
- reset  in  1  asynchronous, active-low (block resets while reset = 0)
- io_sel  in  1  processor IO access this cycle (load or store with addr[13] or addr[12] set)
- wr  in  1  access is a store
- addr  in  32  byte/word address from the processor ALU output
- wdata  in  32  store data
- rdata  out  32  load data, combinational from state
- JA  out  NUM_CH  PWM outputs

## Operation
- Region decode on addr[13:12]:
  - 01 = write region
  - 10 = read region
  - 11 = invalid, ignored, rdata = 0
  - 00 = not ours, rdata = 0
- Register offset is addr[3:0].
- Write strobe: io_sel && wr && region==01. Offset effects:
  - 0..NUM_CH-1: shadow_width[off] <= wdata[CNT_W-1:0]
  - 6: en_mask <= wdata[NUM_CH-1:0]
  - 15: frame_cnt <= 0
  - other offsets: no effect
- Read (io_sel && !wr && region==10), by offset:
  - 0..NUM_CH-1: active_width zero-extended
  - 6: en_mask
  - 7: frame_cnt (32-bit)
  - 8: phase counter zero-extended
  - other offsets: 0
- rdata = 0 whenever the read condition is false.
- Phase counter cnt counts 0..PERIOD-1 and wraps to 0. The wrap cycle is cnt==PERIOD-1.
- On wrap:
  - active_width[i] <= shadow_width[i] for all i.
  - frame_cnt increments, mod 2^32.
- A write to a width register in the wrap cycle bypasses to active: active_width gets the new wdata, not the stale shadow.
- JA[i] = en_mask[i] && (cnt < active_width[i]), registered.
  - width 0: constant low.
  - width ≥ PERIOD: constant high.
- en_mask takes effect on the next cycle, not at a frame boundary.
- Writes to offset 15 and the wrap in the same cycle: frame_cnt becomes 0; the clear wins.

## Timing
- Reset values are all 0: shadow_width, active_width, en_mask, cnt, frame_cnt, JA. rdata is therefore 0.
- Asserting reset mid-frame immediately forces JA low. Counting restarts from cnt=0 on the first rising edge after release.
- Store latency: the register updates at the edge ending the store cycle. JA reflects a width change only after the next wrap; the first affected pulse starts at cnt=0.
- Load latency: 0 cycles. rdata is valid in the same cycle as io_sel/addr, so the processor captures it at its M→W edge.
- JA is registered: one cycle behind the combinational compare. Pulse high time is exactly active_width cycles.
- No stalls and no backpressure; every access completes in one cycle.

## Configuration
- PWM_READBACK_EN defined: read region is decoded as above.
- PWM_READBACK_EN undefined: read decode and mux are removed and rdata is tied to 32'd0. Write behaviour and PWM output are unchanged.

## Structure
- Shared package mmio_pkg holds:
  - region codes: REG_WR=2'b01, REG_RD=2'b10
  - offset constants: OFF_EN=4'd6, OFF_FRAME=4'd7, OFF_PHASE=4'd8, OFF_FCLR=4'd15
- One sub-module, pwm_channel, instantiated NUM_CH times. It holds shadow_width, active_width and the registered compare output. Inputs: cnt, wrap, its write strobe, wdata, enable.
- Top level holds the phase counter, frame counter, en_mask, decode and read mux.

## Test plan
All scenarios use PERIOD=100.
- Reset release → JA=0, rdata=0 on read of any offset; cnt reaches 99 then 0 on the 100th cycle.
- Store 25 to 0x1000 (ch0), store 0x01 to 0x1006, then run two frames → after the next wrap JA[0] is high exactly 25 cycles per 100-cycle frame, and JA[5:1] stay 0.
- Store 40 to ch0 mid-frame (cnt=50) → current frame keeps the old width; the new 40-cycle pulse starts at the following cnt=0.
- Store 70 to ch2 exactly in the cycle cnt=99 → the next frame already uses 70 (bypass). Load 0x2002 → rdata=70.
- Store 0 and then 150 to ch1 with enable set → JA[1] is constant low, then constant high for a whole frame. Load 0x2007 after 3 wraps → rdata=3. Store to 0x100F in a wrap cycle → frame_cnt reads 0.
- Assert reset at cnt=30 with JA[0] high → JA drops the same instant. With PWM_READBACK_EN undefined, load 0x2006 → rdata=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared decode constants for the MMIO PWM responder: address regions
// (addr[13:12]) and register offsets (addr[3:0]).
package mmio_pkg;

    typedef enum logic [1:0] {
        REG_NONE = 2'b00,
        REG_WR   = 2'b01,
        REG_RD   = 2'b10,
        REG_BAD  = 2'b11
    } region_e;

    localparam logic [3:0] OFF_EN    = 4'd6;
    localparam logic [3:0] OFF_FRAME = 4'd7;
    localparam logic [3:0] OFF_PHASE = 4'd8;
    localparam logic [3:0] OFF_FCLR  = 4'd15;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active width pair swapped at the frame wrap and a
// registered compare against the shared phase counter.
module pwm_channel #(
    parameter int CNT_W = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt,
    input  logic             wrap,
    input  logic             we,
    input  logic [CNT_W-1:0] wdata,
    input  logic             enable,
    output logic [CNT_W-1:0] active_width,
    output logic             pwm
);

    logic [CNT_W-1:0] shadow_width;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_width <= '0;
            active_width <= '0;
            pwm          <= 1'b0;
        end else begin
            if (we)
                shadow_width <= wdata;
            // A store landing on the wrap cycle must not be lost behind the stale shadow.
            if (wrap)
                active_width <= we ? wdata : shadow_width;
            pwm <= enable && (cnt < active_width);
        end
    end

endmodule

// File: rtl/mmio_pwm_responder.sv
// MMIO responder driving frame-synchronised PWM on the JA pins.
// Optional load path enabled by defining PWM_READBACK_EN; otherwise rdata is 0.
module mmio_pwm_responder
    import mmio_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int PERIOD = 1000000,
    parameter int CNT_W  = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_sel,
    input  logic              wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] JA
);

    region_e                         region;
    logic [3:0]                      off;
    logic                            wr_stb;
    logic                            wrap;
    logic [CNT_W-1:0]                cnt;
    logic [31:0]                     frame_cnt;
    logic [NUM_CH-1:0]               en_mask;
    logic [NUM_CH-1:0][CNT_W-1:0]    act_w;

    assign region = region_e'(addr[13:12]);
    assign off    = addr[3:0];
    assign wr_stb = io_sel && wr && (region == REG_WR);
    assign wrap   = (cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            frame_cnt <= '0;
            en_mask   <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
            // An explicit clear outranks the wrap increment.
            if (wr_stb && off == OFF_FCLR)
                frame_cnt <= '0;
            else if (wrap)
                frame_cnt <= frame_cnt + 32'd1;
            if (wr_stb && off == OFF_EN)
                en_mask <= wdata[NUM_CH-1:0];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clock        (clock),
            .reset        (reset),
            .cnt          (cnt),
            .wrap         (wrap),
            .we           (wr_stb && off == 4'(i)),
            .wdata        (wdata[CNT_W-1:0]),
            .enable       (en_mask[i]),
            .active_width (act_w[i]),
            .pwm          (JA[i])
        );
    end

`ifdef PWM_READBACK_EN
    logic rd_stb;
    logic unused_bits;

    assign rd_stb      = io_sel && !wr && (region == REG_RD);
    assign unused_bits = ^{addr[31:14], addr[11:4], wdata[31:CNT_W]};

    always_comb begin
        rdata = '0;
        if (rd_stb) begin
            for (int i = 0; i < NUM_CH; i++)
                if (off == 4'(i))
                    rdata = 32'(act_w[i]);
            case (off)
                OFF_EN:    rdata = 32'(en_mask);
                OFF_FRAME: rdata = frame_cnt;
                OFF_PHASE: rdata = 32'(cnt);
                default:   ;
            endcase
        end
    end
`else
    logic unused_bits;

    assign rdata       = '0;
    assign unused_bits = ^{addr[31:14], addr[11:4], wdata[31:CNT_W], frame_cnt, act_w};
`endif

endmodule

// File: tb/tb_mmio_pwm_responder.sv
// Randomised + directed bench for mmio_pwm_responder against a frame-level model.
module tb_mmio_pwm_responder;

    localparam int NUM_CH = 6;
    localparam int PERIOD = 100;
    localparam int CNT_W  = 20;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              io_sel = 1'b0;
    logic              wr = 1'b0;
    logic [31:0]       addr = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] JA;

    always #5 clock = ~clock;

    mmio_pwm_responder #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .CNT_W(CNT_W)) dut (
        .clock  (clock),
        .reset  (reset),
        .io_sel (io_sel),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .JA     (JA)
    );

    int tests = 0;
    int fails = 0;

    // Reference state: position within the frame, frame count, widths, mask, pins.
    int                m_cnt;
    int unsigned       m_frame;
    int                m_shadow [NUM_CH];
    int                m_active [NUM_CH];
    logic [NUM_CH-1:0] m_en;
    logic [NUM_CH-1:0] m_ja;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_frame = 0;
        m_en    = '0;
        m_ja    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
    endtask

    function automatic logic [31:0] model_rdata(input logic s, input logic w, input logic [31:0] a);
        logic [31:0] r;
        int          o;
        r = '0;
        o = int'(a[3:0]);
`ifdef PWM_READBACK_EN
        if (s && !w && a[13:12] == 2'b10) begin
            if (o < NUM_CH)  r = 32'(m_active[o]);
            else if (o == 6) r = 32'(m_en);
            else if (o == 7) r = m_frame;
            else if (o == 8) r = 32'(m_cnt);
        end
`endif
        return r;
    endfunction

    // One clock of the frame rules, using the inputs presented this cycle.
    task automatic model_advance();
        logic wstb;
        int   o, wv;
        logic at_wrap;
        wstb    = io_sel && wr && addr[13:12] == 2'b01;
        o       = int'(addr[3:0]);
        wv      = int'(wdata[CNT_W-1:0]);
        at_wrap = (m_cnt == PERIOD - 1);
        for (int i = 0; i < NUM_CH; i++)
            m_ja[i] = m_en[i] && (m_cnt < m_active[i]);
        for (int i = 0; i < NUM_CH; i++) begin
            if (at_wrap)
                m_active[i] = (wstb && o == i) ? wv : m_shadow[i];
            if (wstb && o == i)
                m_shadow[i] = wv;
        end
        if (wstb && o == 6)
            m_en = wdata[NUM_CH-1:0];
        if (wstb && o == 15)
            m_frame = 0;
        else if (at_wrap)
            m_frame = m_frame + 1;
        m_cnt = (m_cnt + 1) % PERIOD;
    endtask

    task automatic drive(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        io_sel = s;
        wr     = w;
        addr   = a;
        wdata  = d;
        #1;
        check("rdata", rdata, model_rdata(s, w, a));
        check("ja", 32'(JA), 32'(m_ja));
    endtask

    task automatic finish_cycle();
        @(posedge clock);
        if (reset)
            model_advance();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            finish_cycle();
        end
    endtask

    task automatic wr_reg(input logic [3:0] o, input logic [31:0] d);
        drive(1'b1, 1'b1, 32'h1000 | 32'(o), d);
        finish_cycle();
    endtask

    task automatic rd_expect(input string tag, input logic [3:0] o, input logic [31:0] exp);
        drive(1'b1, 1'b0, 32'h2000 | 32'(o), 32'h0);
`ifdef PWM_READBACK_EN
        check(tag, rdata, exp);
`else
        check(tag, rdata, 32'h0);
`endif
        finish_cycle();
    endtask

    // Idle until the frame position equals target; bounded by one frame.
    task automatic wait_cnt(input int target);
        for (int k = 0; k <= PERIOD && m_cnt != target; k++)
            idle(1);
    endtask

    task automatic measure(input int ch, input int n, output int hi, output int others);
        hi     = 0;
        others = 0;
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            if (JA[ch]) hi++;
            if ((JA & ~(NUM_CH'(1) << ch)) != '0) others++;
            finish_cycle();
        end
    endtask

    task automatic random_cycle();
        logic        s, w;
        logic [31:0] a, d;
        int          r;
        s = ($urandom % 4) == 0;
        w = $urandom % 2;
        a = $urandom;
        a[13:12] = 2'($urandom % 4);
        r = $urandom % 12;
        a[3:0] = (r < 9) ? 4'(r) : (r == 9) ? 4'd15 : 4'($urandom % 16);
        d = (($urandom % 3) == 0) ? $urandom : 32'($urandom_range(0, 130));
        drive(s, w, a, d);
        finish_cycle();
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #2 reset = 1'b0;
        #1 check("ja_async_rst", 32'(JA), 32'h0);
        model_reset();
        idle(3);
        #2 reset = 1'b1;
    endtask

    int hi, oth;

    initial begin
        model_reset();
        idle(2);
        rd_expect("rst_rd_w0", 4'd0, 32'd0);
        rd_expect("rst_rd_en", 4'd6, 32'd0);
        rd_expect("rst_rd_frame", 4'd7, 32'd0);
        rd_expect("rst_rd_phase", 4'd8, 32'd0);
        @(posedge clock);
        #2 reset = 1'b1;

        wait_cnt(99);
        rd_expect("phase_99", 4'd8, 32'd99);
        rd_expect("phase_wrap0", 4'd8, 32'd0);

        wr_reg(4'd0, 32'd25);
        wr_reg(4'd6, 32'h01);
        wait_cnt(0);
        idle(1);
        wait_cnt(0);
        measure(0, PERIOD, hi, oth);
        check("ch0_width25", 32'(hi), 32'd25);
        check("ch5_1_quiet", 32'(oth), 32'd0);

        wait_cnt(50);
        wr_reg(4'd0, 32'd40);
        measure(0, PERIOD - 51, hi, oth);
        check("ch0_old_tail", 32'(hi), 32'd0);
        measure(0, PERIOD, hi, oth);
        check("ch0_width40", 32'(hi), 32'd40);

        wr_reg(4'd6, 32'h05);
        wait_cnt(99);
        wr_reg(4'd2, 32'd70);
        measure(2, PERIOD, hi, oth);
        check("ch2_bypass70", 32'(hi), 32'd70);
        rd_expect("rd_ch2", 4'd2, 32'd70);

        wr_reg(4'd6, 32'h07);
        wr_reg(4'd1, 32'd0);
        wait_cnt(0);
        measure(1, PERIOD, hi, oth);
        check("ch1_zero_low", 32'(hi), 32'd0);
        wr_reg(4'd1, 32'd150);
        wait_cnt(0);
        idle(1);
        measure(1, PERIOD, hi, oth);
        check("ch1_full_high", 32'(hi), 32'd100);

        wait_cnt(10);
        wr_reg(4'd15, 32'h0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            wait_cnt(0);
        end
        rd_expect("frame_3", 4'd7, 32'd3);
        wait_cnt(99);
        wr_reg(4'd15, 32'h0);
        rd_expect("frame_clr_wins", 4'd7, 32'd0);
        rd_expect("rd_en", 4'd6, 32'h07);

        wait_cnt(30);
        #1 check("ja0_high_pre_rst", 32'(JA[0]), 32'd1);
        pulse_reset();
        rd_expect("rd_en_after_rst", 4'd6, 32'h0);

        for (int k = 0; k < 3000; k++) begin
            random_cycle();
            if (k == 1500)
                pulse_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
